// File: rtl/axi_multicut_cfg.sv
// AXI pipeline with a separately configurable cut depth and stage mode per channel.
// It also drives an idle flag that is high while no stage on any channel holds a beat.

package axi_multicut_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi_ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    logic    ar_ready;
    axi_r_t  r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_cut_stage #(
  parameter type T    = logic,
  parameter bit  Half = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic busy
);
  if (Half) begin : g_half
    logic valid;
    T     data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid <= 1'b0;
        data  <= '0;
      end else if (valid) begin
        if (out_ready) valid <= 1'b0;
      end else if (in_valid) begin
        valid <= 1'b1;
        data  <= in_data;
      end
    end

    assign in_ready  = !valid;
    assign out_valid = valid;
    assign out_data  = data;
    assign busy      = valid;
  end else begin : g_full
    // Slot a drives the output; slot b catches the beat accepted while a is stalled.
    logic a_valid, b_valid;
    T     a_data, b_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_valid <= 1'b0;
        b_valid <= 1'b0;
        a_data  <= '0;
        b_data  <= '0;
      end else if (!a_valid || out_ready) begin
        if (b_valid) begin
          a_valid <= 1'b1;
          a_data  <= b_data;
          b_valid <= 1'b0;
        end else begin
          a_valid <= in_valid;
          if (in_valid) a_data <= in_data;
        end
      end else if (in_valid && !b_valid) begin
        b_valid <= 1'b1;
        b_data  <= in_data;
      end
    end

    assign in_ready  = !b_valid;
    assign out_valid = a_valid;
    assign out_data  = a_data;
    assign busy      = a_valid | b_valid;
  end
endmodule

module axi_cut_chain #(
  parameter type         T    = logic,
  parameter int unsigned Cuts = 1,
  parameter bit          Half = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic idle
);
  if (Cuts == 0) begin : g_wire
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign idle      = 1'b1;
  end else begin : g_cuts
    logic [Cuts:0]   valid;
    logic [Cuts:0]   ready;
    T                data [Cuts+1];
    logic [Cuts-1:0] busy;

    assign valid[0]    = in_valid;
    assign in_ready    = ready[0];
    assign data[0]     = in_data;
    assign out_valid   = valid[Cuts];
    assign ready[Cuts] = out_ready;
    assign out_data    = data[Cuts];

    for (genvar i = 0; i < Cuts; i++) begin : g_stage
      axi_cut_stage #(.T(T), .Half(Half)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid[i]),
        .in_ready  (ready[i]),
        .in_data   (data[i]),
        .out_valid (valid[i+1]),
        .out_ready (ready[i+1]),
        .out_data  (data[i+1]),
        .busy      (busy[i])
      );
    end

    assign idle = ~|busy;
  end

`ifndef SYNTHESIS
  // A beat offered but not taken must be offered again, unchanged, on the next edge.
  logic in_hold, out_hold;
  T     in_prev, out_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_hold  <= 1'b0;
      out_hold <= 1'b0;
      in_prev  <= '0;
      out_prev <= '0;
    end else begin
      in_hold  <= in_valid && !in_ready;
      out_hold <= out_valid && !out_ready;
      in_prev  <= in_data;
      out_prev <= out_data;
      if (in_hold)
        assert (in_valid && in_data == in_prev)
          else $error("input beat changed or withdrew under backpressure");
      if (out_hold)
        assert (out_valid && out_data == out_prev)
          else $error("output beat changed or withdrew under backpressure");
    end
  end
`endif
endmodule

module axi_multicut_cfg #(
  parameter int unsigned AwCuts = 1,
  parameter int unsigned WCuts  = 1,
  parameter int unsigned BCuts  = 1,
  parameter int unsigned ArCuts = 1,
  parameter int unsigned RCuts  = 1,
  parameter              HalfBw = 5'b00000,
  parameter type aw_chan_t = axi_multicut_pkg::axi_aw_t,
  parameter type w_chan_t  = axi_multicut_pkg::axi_w_t,
  parameter type b_chan_t  = axi_multicut_pkg::axi_b_t,
  parameter type ar_chan_t = axi_multicut_pkg::axi_ar_t,
  parameter type r_chan_t  = axi_multicut_pkg::axi_r_t,
  parameter type req_t     = axi_multicut_pkg::axi_req_t,
  parameter type resp_t    = axi_multicut_pkg::axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i,
  output logic  idle_o
);
  if ($bits(HalfBw) != 5) begin : g_bad_halfbw
    $error("HalfBw must be 5 bits wide, ordered {R,AR,B,W,AW}");
  end

  aw_chan_t   aw_out;
  w_chan_t    w_out;
  b_chan_t    b_out;
  ar_chan_t   ar_out;
  r_chan_t    r_out;
  logic       aw_in_ready, w_in_ready, b_in_ready, ar_in_ready, r_in_ready;
  logic       aw_out_valid, w_out_valid, b_out_valid, ar_out_valid, r_out_valid;
  logic [4:0] chan_idle;

  axi_cut_chain #(.T(aw_chan_t), .Cuts(AwCuts), .Half(HalfBw[0])) u_aw (
    .clk (clk_i), .rst (rst_i),
    .in_valid  (slv_req_i.aw_valid), .in_ready  (aw_in_ready),        .in_data  (slv_req_i.aw),
    .out_valid (aw_out_valid),       .out_ready (mst_resp_i.aw_ready), .out_data (aw_out),
    .idle      (chan_idle[0])
  );

  axi_cut_chain #(.T(w_chan_t), .Cuts(WCuts), .Half(HalfBw[1])) u_w (
    .clk (clk_i), .rst (rst_i),
    .in_valid  (slv_req_i.w_valid), .in_ready  (w_in_ready),         .in_data  (slv_req_i.w),
    .out_valid (w_out_valid),       .out_ready (mst_resp_i.w_ready), .out_data (w_out),
    .idle      (chan_idle[1])
  );

  // B and R run master-to-slave, so their chains are wired the other way round.
  axi_cut_chain #(.T(b_chan_t), .Cuts(BCuts), .Half(HalfBw[2])) u_b (
    .clk (clk_i), .rst (rst_i),
    .in_valid  (mst_resp_i.b_valid), .in_ready  (b_in_ready),        .in_data  (mst_resp_i.b),
    .out_valid (b_out_valid),        .out_ready (slv_req_i.b_ready), .out_data (b_out),
    .idle      (chan_idle[2])
  );

  axi_cut_chain #(.T(ar_chan_t), .Cuts(ArCuts), .Half(HalfBw[3])) u_ar (
    .clk (clk_i), .rst (rst_i),
    .in_valid  (slv_req_i.ar_valid), .in_ready  (ar_in_ready),         .in_data  (slv_req_i.ar),
    .out_valid (ar_out_valid),       .out_ready (mst_resp_i.ar_ready), .out_data (ar_out),
    .idle      (chan_idle[3])
  );

  axi_cut_chain #(.T(r_chan_t), .Cuts(RCuts), .Half(HalfBw[4])) u_r (
    .clk (clk_i), .rst (rst_i),
    .in_valid  (mst_resp_i.r_valid), .in_ready  (r_in_ready),        .in_data  (mst_resp_i.r),
    .out_valid (r_out_valid),        .out_ready (slv_req_i.r_ready), .out_data (r_out),
    .idle      (chan_idle[4])
  );

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = aw_out;
    mst_req_o.aw_valid = aw_out_valid;
    mst_req_o.w        = w_out;
    mst_req_o.w_valid  = w_out_valid;
    mst_req_o.b_ready  = b_in_ready;
    mst_req_o.ar       = ar_out;
    mst_req_o.ar_valid = ar_out_valid;
    mst_req_o.r_ready  = r_in_ready;
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_in_ready;
    slv_resp_o.w_ready  = w_in_ready;
    slv_resp_o.b        = b_out;
    slv_resp_o.b_valid  = b_out_valid;
    slv_resp_o.ar_ready = ar_in_ready;
    slv_resp_o.r        = r_out;
    slv_resp_o.r_valid  = r_out_valid;
  end

  assign idle_o = &chan_idle;
endmodule

// File: tb/tb_axi_multicut_cfg.sv
// Directed bench for axi_multicut_cfg with a per-channel scoreboard.
// DUT settings: AW 3 full, W 2 half, B pass-through, AR 2 full, R 2 full.

module tb_axi_multicut_cfg;
  import axi_multicut_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;
  logic      idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  axi_aw_t exp_aw[$];
  axi_w_t  exp_w[$];
  axi_b_t  exp_b[$];
  axi_ar_t exp_ar[$];
  axi_r_t  exp_r[$];

  int aw_out_cnt = 0, w_out_cnt = 0, b_out_cnt = 0, ar_out_cnt = 0, r_out_cnt = 0;
  int w_first_in = -1, w_last_out = -1;

  axi_multicut_cfg #(
    .AwCuts (3),
    .WCuts  (2),
    .BCuts  (0),
    .ArCuts (2),
    .RCuts  (2),
    .HalfBw (5'b00010)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .idle_o     (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle; each one completes on the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (slv_req.aw_valid && slv_resp.aw_ready) exp_aw.push_back(slv_req.aw);
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        aw_out_cnt++;
        check("aw_sb_entry", 64'(exp_aw.size() != 0), 64'(1));
        if (exp_aw.size() != 0) check("aw_order", 64'(mst_req.aw), 64'(exp_aw.pop_front()));
      end
      if (slv_req.w_valid && slv_resp.w_ready) begin
        exp_w.push_back(slv_req.w);
        if (w_first_in < 0) w_first_in = cyc + 1;
      end
      if (mst_req.w_valid && mst_resp.w_ready) begin
        w_out_cnt++;
        w_last_out = cyc + 1;
        check("w_sb_entry", 64'(exp_w.size() != 0), 64'(1));
        if (exp_w.size() != 0) check("w_order", 64'(mst_req.w), 64'(exp_w.pop_front()));
      end
      if (mst_resp.b_valid && mst_req.b_ready) exp_b.push_back(mst_resp.b);
      if (slv_resp.b_valid && slv_req.b_ready) begin
        b_out_cnt++;
        check("b_sb_entry", 64'(exp_b.size() != 0), 64'(1));
        if (exp_b.size() != 0) check("b_order", 64'(slv_resp.b), 64'(exp_b.pop_front()));
      end
      if (slv_req.ar_valid && slv_resp.ar_ready) exp_ar.push_back(slv_req.ar);
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        ar_out_cnt++;
        check("ar_sb_entry", 64'(exp_ar.size() != 0), 64'(1));
        if (exp_ar.size() != 0) check("ar_order", 64'(mst_req.ar), 64'(exp_ar.pop_front()));
      end
      if (mst_resp.r_valid && mst_req.r_ready) exp_r.push_back(mst_resp.r);
      if (slv_resp.r_valid && slv_req.r_ready) begin
        r_out_cnt++;
        check("r_sb_entry", 64'(exp_r.size() != 0), 64'(1));
        if (exp_r.size() != 0) check("r_order", 64'(slv_resp.r), 64'(exp_r.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs;
    int   sent;

    slv_req  = '0;
    mst_resp = '0;
    rst      = 1'b1;

    // Reset, then idle values.
    repeat (3) step();
    check("rst_held_idle", 64'(idle), 64'(1));
    check("rst_held_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    rst = 1'b0;
    step();
    check("rst_aw_ready", 64'(slv_resp.aw_ready), 64'(1));
    check("rst_w_ready", 64'(slv_resp.w_ready), 64'(1));
    check("rst_ar_ready", 64'(slv_resp.ar_ready), 64'(1));
    check("rst_b_valid", 64'(slv_resp.b_valid), 64'(0));
    check("rst_r_valid", 64'(slv_resp.r_valid), 64'(0));
    check("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    check("rst_mst_w_valid", 64'(mst_req.w_valid), 64'(0));
    check("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'(0));
    check("rst_mst_r_ready", 64'(mst_req.r_ready), 64'(1));
    check("rst_idle", 64'(idle), 64'(1));

    // AW: three full stages, 16 back-to-back beats.
    mst_resp.aw_ready = 1'b1;
    slv_req.aw_valid  = 1'b1;
    slv_req.aw.addr   = 32'h1000;
    slv_req.aw.prot   = 3'd1;
    for (int j = 1; j <= 21; j++) begin
      step();
      check("aw_valid_window", 64'(mst_req.aw_valid), 64'(j >= 3 && j <= 18));
      check("aw_idle", 64'(idle), 64'(j >= 19));
      check("aw_ready_full_bw", 64'(slv_resp.aw_ready), 64'(1));
      if (j < 16) slv_req.aw.addr = 32'h1000 + 32'(j * 4);
      else slv_req.aw_valid = 1'b0;
    end
    check("aw_beats_out", 64'(aw_out_cnt), 64'(16));

    // W: two half-bandwidth stages, 10 beats at one per two cycles.
    mst_resp.w_ready = 1'b1;
    slv_req.w_valid  = 1'b1;
    slv_req.w.data   = 32'hA000_0000;
    slv_req.w.strb   = 4'hF;
    sent = 0;
    for (int n = 0; n < 60 && w_out_cnt < 10; n++) begin
      hs = slv_req.w_valid && slv_resp.w_ready;
      step();
      if (hs) begin
        sent++;
        check("w_ready_after_accept", 64'(slv_resp.w_ready), 64'(0));
        if (sent < 10) slv_req.w.data = 32'hA000_0000 + 32'(sent);
        else slv_req.w_valid = 1'b0;
      end
    end
    check("w_beats_in", 64'(sent), 64'(10));
    check("w_beats_out", 64'(w_out_cnt), 64'(10));
    check("w_span_19_to_21", 64'((w_last_out - w_first_in) inside {[19:21]}), 64'(1));
    repeat (2) step();

    // R: slave side stalled, four beats fill the two spill stages.
    slv_req.r_ready   = 1'b0;
    mst_resp.r_valid  = 1'b1;
    mst_resp.r.data   = 32'hB000_0000;
    mst_resp.r.resp   = 2'b00;
    sent = 0;
    for (int n = 0; n < 20 && sent < 4; n++) begin
      hs = mst_resp.r_valid && mst_req.r_ready;
      step();
      if (hs) begin
        sent++;
        mst_resp.r.data = 32'hB000_0000 + 32'(sent);
      end
    end
    check("r_stored", 64'(sent), 64'(4));
    check("r_ready_drop", 64'(mst_req.r_ready), 64'(0));
    repeat (4) begin
      hs = mst_resp.r_valid && mst_req.r_ready;
      step();
      check("r_fifth_stalls", 64'(hs), 64'(0));
      check("r_ready_low", 64'(mst_req.r_ready), 64'(0));
      check("r_slv_valid", 64'(slv_resp.r_valid), 64'(1));
      check("r_slv_data_stable", 64'(slv_resp.r.data), 64'(32'hB000_0000));
    end
    slv_req.r_ready = 1'b1;
    for (int n = 0; n < 30 && r_out_cnt < 5; n++) begin
      hs = mst_resp.r_valid && mst_req.r_ready;
      step();
      if (hs) begin
        sent++;
        if (sent == 5) mst_resp.r_valid = 1'b0;
      end
    end
    check("r_beats_in", 64'(sent), 64'(5));
    check("r_beats_out", 64'(r_out_cnt), 64'(5));
    step();

    // B: zero cuts, so valid, payload and ready all pass combinationally.
    mst_resp.b_valid = 1'b1;
    mst_resp.b.resp  = 2'b10;
    slv_req.b_ready  = 1'b0;
    #1;
    check("b_pass_valid", 64'(slv_resp.b_valid), 64'(1));
    check("b_pass_data", 64'(slv_resp.b.resp), 64'(2'b10));
    check("b_ready_comb_low", 64'(mst_req.b_ready), 64'(0));
    check("b_idle_unaffected", 64'(idle), 64'(1));
    slv_req.b_ready = 1'b1;
    #1;
    check("b_ready_comb_high", 64'(mst_req.b_ready), 64'(1));
    step();
    mst_resp.b_valid = 1'b0;
    slv_req.b_ready  = 1'b0;
    check("b_beats_out", 64'(b_out_cnt), 64'(1));

    // AR: hold three beats, then a half-cycle asynchronous reset discards them.
    mst_resp.ar_ready = 1'b0;
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.addr   = 32'hC000_0000;
    slv_req.ar.prot   = 3'd2;
    sent = 0;
    for (int n = 0; n < 20 && sent < 3; n++) begin
      hs = slv_req.ar_valid && slv_resp.ar_ready;
      step();
      if (hs) begin
        sent++;
        if (sent < 3) slv_req.ar.addr = 32'hC000_0000 + 32'(sent * 16);
        else slv_req.ar_valid = 1'b0;
      end
    end
    check("ar_accepted", 64'(sent), 64'(3));
    step();
    check("ar_held_valid", 64'(mst_req.ar_valid), 64'(1));
    check("ar_held_busy", 64'(idle), 64'(0));
    #1 rst = 1'b1;
    #1;
    check("ar_rst_valid", 64'(mst_req.ar_valid), 64'(0));
    check("ar_rst_idle", 64'(idle), 64'(1));
    exp_ar.delete();
    mst_resp.ar_ready = 1'b1;
    #3 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("ar_no_emit", 64'(mst_req.ar_valid), 64'(0));
      check("ar_post_rst_idle", 64'(idle), 64'(1));
    end
    check("ar_post_rst_ready", 64'(slv_resp.ar_ready), 64'(1));
    check("ar_beats_out", 64'(ar_out_cnt), 64'(0));

    check("sb_drained", 64'(exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
